puzzle_tile_ctrl: RTL and testbench



---
 rtl/puzzle_pkg.sv | 70 +++++++
 rtl/puzzle_tile_ctrl_lfsr16.sv | 34 +++
 rtl/puzzle_tile_ctrl.sv | 171 +++++++++++++++++
 tb/tb_puzzle_tile_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puzzle_pkg
// Description : Shared definitions for the 2x2 sliding-tile puzzle: tile and
//               position codes, sequencer state encoding and layout helpers.
//               Layout word: [11:9]=a(TL) [8:6]=b(TR) [5:3]=c(BL) [2:0]=d(BR).
// Revision    : 1.0 - initial release
// ============================================================================
package puzzle_pkg;

    localparam logic [2:0] TILE_BLANK = 3'd4;

    localparam logic [1:0] POS_A = 2'd0;
    localparam logic [1:0] POS_B = 2'd1;
    localparam logic [1:0] POS_C = 2'd2;
    localparam logic [1:0] POS_D = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SHUF = 2'd2;

    // Tile code stored at position p.
    function automatic logic [2:0] tile_get(input logic [11:0] layout, input logic [1:0] p);
        logic [2:0] t;
        case (p)
            POS_A:   t = layout[11:9];
            POS_B:   t = layout[8:6];
            POS_C:   t = layout[5:3];
            default: t = layout[2:0];
        endcase
        return t;
    endfunction

    // Layout with position p overwritten by tile t.
    function automatic logic [11:0] tile_put(input logic [11:0] layout, input logic [1:0] p,
                                             input logic [2:0] t);
        logic [11:0] res;
        res = layout;
        case (p)
            POS_A:   res[11:9] = t;
            POS_B:   res[8:6]  = t;
            POS_C:   res[5:3]  = t;
            default: res[2:0]  = t;
        endcase
        return res;
    endfunction

    // Exchange the tiles at positions p0 and p1.
    function automatic logic [11:0] tile_swap(input logic [11:0] layout, input logic [1:0] p0,
                                              input logic [1:0] p1);
        logic [11:0] res;
        res = tile_put(layout, p0, tile_get(layout, p1));
        res = tile_put(res, p1, tile_get(layout, p0));
        return res;
    endfunction

    // Position holding the blank code (used at elaboration for the reset value).
    function automatic logic [1:0] blank_index(input logic [11:0] layout);
        logic [1:0] idx;
        idx = POS_A;
        for (int i = 0; i < 4; i++) begin
            if (tile_get(layout, 2'(i)) == TILE_BLANK) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/puzzle_tile_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
//               Advances every clock; only rst reloads the seed.
// Ports       : clk, rst (async, active-high), q[15:0] current state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    // Right-shifting form: tap 16 is bit 0, taps 14/13/11 are bits 2/3/5.
    assign w_fb = r_q[0] ^ r_q[2] ^ r_q[3] ^ r_q[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= SEED;
        end else begin
            r_q <= {w_fb, r_q[15:1]};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/puzzle_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : puzzle_tile_ctrl
// Description : Sequencer for the 2x2 sliding-tile display. Turns button
//               pulses into legal blank moves (or a random shuffle) and
//               commits every layout change on a frame_start boundary.
// Ports       : clk, rst (async, active-high)
//               btn_up/down/left/right/shuffle - 1-cycle button pulses
//               frame_start - 1-cycle pulse at vblank start
//               img_nums[11:0] layout, blank_pos[1:0], busy, solved,
//               move_count[15:0] (saturating player move count)
// Revision    : 1.0 - initial release
// ============================================================================
module puzzle_tile_ctrl
    import puzzle_pkg::*;
#(
    parameter int          SHUFFLE_MOVES = 15,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [11:0] RESET_LAYOUT  = 12'b100_011_010_001,
    parameter logic [11:0] SOLVED_LAYOUT = 12'b000_001_010_100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_shuffle,
    input  logic        frame_start,
    output logic [11:0] img_nums,
    output logic [1:0]  blank_pos,
    output logic        busy,
    output logic        solved,
    output logic [15:0] move_count
);

    localparam logic [1:0] c_reset_blank  = blank_index(RESET_LAYOUT);
    localparam logic       c_reset_solved = (RESET_LAYOUT == SOLVED_LAYOUT);
    localparam logic [7:0] c_shuf_moves   = 8'(SHUFFLE_MOVES);

    logic [1:0]  r_state,    w_state_nxt;
    logic [1:0]  r_target,   w_target_nxt;
    logic [7:0]  r_shuf_cnt, w_shuf_cnt_nxt;
    logic [11:0] r_img,      w_img_nxt;
    logic [1:0]  r_blank,    w_blank_nxt;
    logic        r_solved,   w_solved_nxt;
    logic [15:0] r_moves,    w_moves_nxt;
    logic        r_busy;

    logic [15:0] w_lfsr;
    logic        w_dir_ok;
    logic [1:0]  w_dir_target;
    logic [1:0]  w_shuf_target;
    logic [11:0] w_pend_layout;
    logic [11:0] w_shuf_layout;
    logic        w_shuf_last;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // Direction decode: only the highest-priority pressed button is
    // considered; if that one is illegal the request is dropped outright.
    always_comb begin
        w_dir_ok     = 1'b0;
        w_dir_target = r_blank;
        if (btn_up) begin
            w_dir_ok     = r_blank[1];
            w_dir_target = r_blank ^ 2'b10;
        end else if (btn_down) begin
            w_dir_ok     = ~r_blank[1];
            w_dir_target = r_blank ^ 2'b10;
        end else if (btn_left) begin
            w_dir_ok     = r_blank[0];
            w_dir_target = r_blank ^ 2'b01;
        end else if (btn_right) begin
            w_dir_ok     = ~r_blank[0];
            w_dir_target = r_blank ^ 2'b01;
        end
    end

    // Any neighbour of the blank is a legal move, so the LFSR bit only
    // chooses between the horizontal and vertical partner.
    assign w_shuf_target = r_blank ^ (w_lfsr[0] ? 2'b10 : 2'b01);
    assign w_pend_layout = tile_swap(r_img, r_blank, r_target);
    assign w_shuf_layout = tile_swap(r_img, r_blank, w_shuf_target);
    assign w_shuf_last   = (r_shuf_cnt <= 8'd1);

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_shuf_cnt_nxt = r_shuf_cnt;
        w_img_nxt      = r_img;
        w_blank_nxt    = r_blank;
        w_solved_nxt   = r_solved;
        w_moves_nxt    = r_moves;
        case (r_state)
            ST_IDLE: begin
                if (btn_shuffle) begin
                    w_moves_nxt    = 16'd0;
                    w_shuf_cnt_nxt = c_shuf_moves;
                    w_state_nxt    = ST_SHUF;
                end else if (w_dir_ok) begin
                    w_target_nxt = w_dir_target;
                    w_state_nxt  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (frame_start) begin
                    w_img_nxt    = w_pend_layout;
                    w_blank_nxt  = r_target;
                    w_solved_nxt = (w_pend_layout == SOLVED_LAYOUT);
                    if (r_moves != 16'hFFFF) begin
                        w_moves_nxt = r_moves + 16'd1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHUF: begin
                if (frame_start) begin
                    w_img_nxt      = w_shuf_layout;
                    w_blank_nxt    = w_shuf_target;
                    w_solved_nxt   = (w_shuf_layout == SOLVED_LAYOUT);
                    w_shuf_cnt_nxt = w_shuf_last ? 8'd0 : r_shuf_cnt - 8'd1;
                    // Never hand back a solved puzzle: keep moving one frame
                    // at a time until the layout differs from the target.
                    if (w_shuf_last && (w_shuf_layout != SOLVED_LAYOUT)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_target   <= c_reset_blank;
            r_shuf_cnt <= 8'd0;
            r_img      <= RESET_LAYOUT;
            r_blank    <= c_reset_blank;
            r_solved   <= c_reset_solved;
            r_moves    <= 16'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_shuf_cnt <= w_shuf_cnt_nxt;
            r_img      <= w_img_nxt;
            r_blank    <= w_blank_nxt;
            r_solved   <= w_solved_nxt;
            r_moves    <= w_moves_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign img_nums   = r_img;
    assign blank_pos  = r_blank;
    assign busy       = r_busy;
    assign solved     = r_solved;
    assign move_count = r_moves;

endmodule
`default_nettype wire

// File: tb/tb_puzzle_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_puzzle_tile_ctrl
// Description : Self-checking bench for puzzle_tile_ctrl: a one-cycle-per-
//               entry vector table plus directed multi-cycle sequences.
//               A second instance starts one move away from the solved
//               layout to exercise the solved flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puzzle_tile_ctrl;

    localparam logic [11:0] c_reset  = 12'b100_011_010_001;
    localparam logic [11:0] c_solved = 12'b000_001_010_100;
    localparam logic [11:0] c_near   = 12'b000_001_100_010;

    // {up, down, left, right, shuffle, frame_start}
    localparam logic [5:0] B_UP = 6'b100000;
    localparam logic [5:0] B_DN = 6'b010000;
    localparam logic [5:0] B_LF = 6'b001000;
    localparam logic [5:0] B_RT = 6'b000100;
    localparam logic [5:0] B_SH = 6'b000010;
    localparam logic [5:0] B_FR = 6'b000001;
    localparam logic [5:0] B_NO = 6'b000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  in1 = '0;
    logic [5:0]  in2 = '0;
    logic [11:0] img1, img2;
    logic [1:0]  blank1, blank2;
    logic        busy1, busy2, solved1, solved2;
    logic [15:0] mc1, mc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    puzzle_tile_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (in1[5]),
        .btn_down    (in1[4]),
        .btn_left    (in1[3]),
        .btn_right   (in1[2]),
        .btn_shuffle (in1[1]),
        .frame_start (in1[0]),
        .img_nums    (img1),
        .blank_pos   (blank1),
        .busy        (busy1),
        .solved      (solved1),
        .move_count  (mc1)
    );

    puzzle_tile_ctrl #(
        .RESET_LAYOUT (c_near)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (in2[5]),
        .btn_down    (in2[4]),
        .btn_left    (in2[3]),
        .btn_right   (in2[2]),
        .btn_shuffle (in2[1]),
        .frame_start (in2[0]),
        .img_nums    (img2),
        .blank_pos   (blank2),
        .busy        (busy2),
        .solved      (solved2),
        .move_count  (mc2)
    );

    typedef struct {
        logic [5:0]  in;
        logic [11:0] img;
        logic [1:0]  blank;
        logic        busy;
        logic [15:0] mc;
        logic        solved;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [5:0] in, input logic [11:0] img,
                                input logic [1:0] blank, input logic busy,
                                input logic [15:0] mc, input logic solved);
        vec_t v;
        v.in = in; v.img = img; v.blank = blank; v.busy = busy; v.mc = mc; v.solved = solved;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs set on the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic drive(input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in1 = '0;
        in2 = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [2:0] field(input logic [11:0] l, input int i);
        return l[(3 - i) * 3 +: 3];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int frames;
        int guard;
        int cnt[5];
        int bpos;

        // Blank starts at a. Each entry is one cycle; expectations hold after that edge.
        vecs[0]  = mk(B_NO,             c_reset,             2'd0, 1'b0, 16'd0, 1'b0);
        vecs[1]  = mk(B_UP,             c_reset,             2'd0, 1'b0, 16'd0, 1'b0);
        vecs[2]  = mk(B_LF,             c_reset,             2'd0, 1'b0, 16'd0, 1'b0);
        vecs[3]  = mk(B_RT,             c_reset,             2'd0, 1'b1, 16'd0, 1'b0);
        vecs[4]  = mk(B_NO,             c_reset,             2'd0, 1'b1, 16'd0, 1'b0);
        vecs[5]  = mk(B_LF,             c_reset,             2'd0, 1'b1, 16'd0, 1'b0);
        vecs[6]  = mk(B_FR,             12'b011_100_010_001, 2'd1, 1'b0, 16'd1, 1'b0);
        vecs[7]  = mk(B_FR,             12'b011_100_010_001, 2'd1, 1'b0, 16'd1, 1'b0);
        // down latched in the same cycle as a frame_start in IDLE: waits for the next frame
        vecs[8]  = mk(B_DN | B_RT | B_FR, 12'b011_100_010_001, 2'd1, 1'b1, 16'd1, 1'b0);
        vecs[9]  = mk(B_FR,             12'b011_001_010_100, 2'd3, 1'b0, 16'd2, 1'b0);
        vecs[10] = mk(B_DN,             12'b011_001_010_100, 2'd3, 1'b0, 16'd2, 1'b0);
        vecs[11] = mk(B_RT,             12'b011_001_010_100, 2'd3, 1'b0, 16'd2, 1'b0);
        vecs[12] = mk(B_UP,             12'b011_001_010_100, 2'd3, 1'b1, 16'd2, 1'b0);
        vecs[13] = mk(B_FR,             12'b011_100_010_001, 2'd1, 1'b0, 16'd3, 1'b0);
        // up (illegal at b) outranks left (legal): request dropped
        vecs[14] = mk(B_UP | B_LF,      12'b011_100_010_001, 2'd1, 1'b0, 16'd3, 1'b0);
        vecs[15] = mk(B_NO,             12'b011_100_010_001, 2'd1, 1'b0, 16'd3, 1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].in, B_NO);
            check($sformatf("v%0d img", i), 32'(img1), 32'(vecs[i].img));
            check($sformatf("v%0d blank", i), 32'(blank1), 32'(vecs[i].blank));
            check($sformatf("v%0d busy", i), 32'(busy1), 32'(vecs[i].busy));
            check($sformatf("v%0d moves", i), 32'(mc1), 32'(vecs[i].mc));
            check($sformatf("v%0d solved", i), 32'(solved1), 32'(vecs[i].solved));
        end

        // Solved flag on the second instance (blank at c, one move from solved).
        check("s2 reset solved", 32'(solved2), 32'd0);
        check("s2 reset blank", 32'(blank2), 32'd2);
        drive(B_NO, B_RT);
        check("s2 pend solved", 32'(solved2), 32'd0);
        drive(B_NO, B_FR);
        check("s2 img", 32'(img2), 32'(c_solved));
        check("s2 solved", 32'(solved2), 32'd1);
        drive(B_NO, B_UP);
        check("s2 held solved", 32'(solved2), 32'd1);
        drive(B_NO, B_FR);
        check("s2 unsolved img", 32'(img2), 32'b000_100_010_001);
        check("s2 unsolved", 32'(solved2), 32'd0);

        // Shuffle wins over a simultaneous direction and clears the move count.
        drive(B_SH | B_RT, B_NO);
        check("shuf busy", 32'(busy1), 32'd1);
        check("shuf moves clr", 32'(mc1), 32'd0);
        frames = 0;
        guard = 0;
        while (busy1 && guard < 100) begin
            drive(B_UP | B_LF | B_SH, B_NO);
            drive(B_FR | B_DN | B_RT, B_NO);
            frames++;
            guard++;
        end
        check("shuf timeout", 32'(guard < 100), 32'd1);
        // The tile set {1,2,3,4} can never form the solved layout, so no extra move.
        check("shuf frames", 32'(frames), 32'd15);
        drive(B_NO, B_NO);
        check("shuf end busy", 32'(busy1), 32'd0);
        check("shuf end moves", 32'(mc1), 32'd0);
        check("shuf end solved", 32'(solved1), 32'd0);
        for (int k = 0; k < 5; k++) cnt[k] = 0;
        bpos = 0;
        for (int p = 0; p < 4; p++) begin
            if (field(img1, p) <= 3'd4) cnt[field(img1, p)]++;
            if (field(img1, p) == 3'd4) bpos = p;
        end
        check("shuf one blank", 32'(cnt[4]), 32'd1);
        check("shuf tile set", 32'(cnt[1] == 1 && cnt[2] == 1 && cnt[3] == 1), 32'd1);
        check("shuf blank_pos", 32'(blank1), 32'(bpos));

        // Asynchronous reset in the middle of a shuffle.
        drive(B_SH, B_NO);
        drive(B_FR, B_NO);
        drive(B_FR, B_NO);
        check("rst pre busy", 32'(busy1), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst img", 32'(img1), 32'(c_reset));
        check("arst busy", 32'(busy1), 32'd0);
        check("arst blank", 32'(blank1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Down beats right from the reset layout.
        drive(B_DN | B_RT, B_NO);
        check("dr busy", 32'(busy1), 32'd1);
        drive(B_FR, B_NO);
        check("dr img", 32'(img1), 32'b010_011_100_001);
        check("dr blank", 32'(blank1), 32'd2);
        check("dr moves", 32'(mc1), 32'd1);

        // Move counter saturation.
        do_reset();
        @(negedge clk);
        force dut.r_moves = 16'hFFFE;
        @(negedge clk);
        release dut.r_moves;
        drive(B_RT, B_NO);
        drive(B_FR, B_NO);
        check("sat1 moves", 32'(mc1), 32'hFFFF);
        check("sat1 img", 32'(img1), 32'b011_100_010_001);
        drive(B_LF, B_NO);
        drive(B_FR, B_NO);
        check("sat2 moves", 32'(mc1), 32'hFFFF);
        check("sat2 img", 32'(img1), 32'(c_reset));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
